rc4_stream_ctrl: RTL
====================

RC4_STREAM_CTRL -- requirements
Module: rc4_stream_ctrl

Interface
REQ-001 SHALL have parameter KEY_MAX, default 16, maximum key length in bytes (1..256).
REQ-002 SHALL have parameter KSA_TIMEOUT, default 1024, cycles allowed for the core key schedule.
REQ-003 SHALL have port wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port key_we / key_addr / key_data  in  1 / clog2(KEY_MAX) / 8  host key-byte write.
REQ-006 SHALL have port key_len  in  clog2(KEY_MAX)+1  key length, sampled at start.
REQ-007 SHALL have port msg_len  in  16  byte count, sampled at start.
REQ-008 SHALL have port start  in  1  one-cycle session request.
REQ-009 SHALL have ports din_valid/din_ready/din  in/out/in  1/1/8  plaintext stream.
REQ-010 SHALL have ports dout_valid/dout_ready/dout  out/in/out  1/1/8  ciphertext stream.
REQ-011 SHALL have ports core_key_valid/core_key_last/core_key_byte/core_key_ready  out/out/out/in  1/1/8/1  key feed to RC4 core.
REQ-012 SHALL have ports core_init/core_init_done  out/in  1/1  KSA start pulse and completion pulse.
REQ-013 SHALL have ports core_ks_valid/core_ks_byte/core_ks_ready  in/in/out  1/8/1  keystream from core.
REQ-014 SHALL have ports busy/done/err  out/out/out  1/1/1  status.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD_KEY, KSA_WAIT, STREAM, FINISH.
REQ-016 IDLE: key_we writes key_data into key buffer entry key_addr; writes outside IDLE SHALL be ignored.
REQ-017 IDLE + start: key_len in 1..KEY_MAX -> latch key_len, msg_len, clear err, go LOAD_KEY; otherwise set err, stay IDLE.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 LOAD_KEY: core_key_valid high, core_key_byte = buffer[idx], idx advances on valid&ready; core_key_last high when idx = key_len-1; last transfer -> KSA_WAIT with core_init pulsed one cycle.
REQ-020 KSA_WAIT: core_init_done -> STREAM; cycle counter reaching KSA_TIMEOUT -> set err, go IDLE.
REQ-021 STREAM: take = din_valid & core_ks_valid & (!dout_valid | dout_ready); din_ready = core_ks_ready = take.
REQ-022 On take: dout <= din XOR core_ks_byte, dout_valid <= 1 next cycle (latency 1), remaining count decrements.
REQ-023 dout_valid & !dout_ready SHALL hold dout stable; dout_valid clears on dout_ready with no take.
REQ-024 Remaining count reaching 0 -> FINISH; msg_len = 0 -> FINISH directly from KSA_WAIT, no bytes consumed.
REQ-025 FINISH: wait for final dout accepted, then pulse done one cycle, go IDLE.
REQ-026 Full throughput: one byte per cycle when din, keystream, and dout_ready continuously asserted.
REQ-027 busy SHALL be high in every state except IDLE.
REQ-028 err SHALL be sticky until the next accepted start or reset.

Reset
REQ-029 wb_rst_i SHALL force IDLE, all counters 0, and busy/done/err/dout_valid/din_ready/core_key_valid/core_init/core_ks_ready to 0 on the next edge, including mid-session.
REQ-030 The key buffer SHALL NOT be cleared by reset.
REQ-031 dout SHALL reset to 8'h00.

Structure
REQ-032 The FSM state enum, KEY_MAX, and KSA_TIMEOUT defaults SHALL live in shared package rc4_ctrl_pkg.
REQ-033 The key storage and read mux SHALL be one sub-module, rc4_key_buf.

Verification
REQ-034 Key 01 02 03 04 05, key_len 5, core_key_ready stalls 1 cycle per byte -> five bytes in order; core_key_last with 05; then one core_init pulse.
REQ-035 msg_len 4, din 00 FF 55 AA, ks 12 34 56 78 -> dout 12 CB 03 D2; done pulses once; busy falls with done.
REQ-036 dout_ready low 3 cycles mid-stream -> dout stable; no din or ks consumed during the stall; no byte lost or duplicated.
REQ-037 key_len 0, or core_init_done withheld 1024 cycles -> err=1, state IDLE, no dout_valid.
REQ-038 wb_rst_i asserted during STREAM after 2 of 8 bytes -> next cycle all outputs at reset values; a fresh start with the same key works.
REQ-039 start during STREAM and key_we during KSA_WAIT -> both ignored; buffer contents and session unaffected.

Source files
------------

// File: rtl/rc4_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rc4_ctrl_pkg
// Shared definitions for the RC4 stream controller: session FSM encoding,
// default parameter values and a small key-length range helper.
// -----------------------------------------------------------------------------
package rc4_ctrl_pkg;

  localparam int KEY_MAX_DEFAULT     = 16;
  localparam int KSA_TIMEOUT_DEFAULT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_KEY = 3'd1,
    ST_KSA_WAIT = 3'd2,
    ST_STREAM   = 3'd3,
    ST_FINISH   = 3'd4
  } rc4_state_e;

  // A key length is usable when it names at least one byte and fits the buffer.
  function automatic logic key_len_in_range(input int unsigned len,
                                            input int unsigned max_len);
    return (len >= 32'd1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/rc4_key_buf.sv
// -----------------------------------------------------------------------------
// rc4_key_buf
// Byte-wide key storage with one write port and an asynchronous read mux.
// Contents are deliberately not reset so a key survives a controller reset.
//
// Ports:
//   clk    in   clock
//   we     in   write enable (gated to IDLE by the controller)
//   waddr  in   write address
//   wdata  in   write byte
//   raddr  in   read address
//   rdata  out  byte at raddr
// -----------------------------------------------------------------------------
module rc4_key_buf
  import rc4_ctrl_pkg::*;
#(
  parameter  int DEPTH   = KEY_MAX_DEFAULT,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int ENTRIES = 1 << AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  // Full power-of-two array: out-of-range writes land in entries never read.
  logic [7:0] mem_r [ENTRIES];

  // Key byte write port, no reset on storage
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/rc4_stream_ctrl.sv
// -----------------------------------------------------------------------------
// rc4_stream_ctrl
// Session controller around an external RC4 core: loads the key into the
// core, waits for the key schedule, then XORs plaintext with keystream.
//
// Ports:
//   wb_clk_i / wb_rst_i             clock, synchronous active-high reset
//   key_we/key_addr/key_data        host key-byte writes (IDLE only)
//   key_len, msg_len, start         session setup, sampled on start
//   din_valid/din_ready/din         plaintext stream in
//   dout_valid/dout_ready/dout      ciphertext stream out
//   core_key_valid/last/byte/ready  key feed to the RC4 core
//   core_init, core_init_done       key-schedule start / completion pulses
//   core_ks_valid/byte/ready        keystream from the core
//   busy, done, err                 status
// -----------------------------------------------------------------------------
module rc4_stream_ctrl
  import rc4_ctrl_pkg::*;
#(
  parameter  int KEY_MAX     = KEY_MAX_DEFAULT,
  parameter  int KSA_TIMEOUT = KSA_TIMEOUT_DEFAULT,
  localparam int KAW         = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1,
  localparam int KLW         = $clog2(KEY_MAX) + 1
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic           key_we,
  input  logic [KAW-1:0] key_addr,
  input  logic [7:0]     key_data,
  input  logic [KLW-1:0] key_len,
  input  logic [15:0]    msg_len,
  input  logic           start,
  input  logic           din_valid,
  output logic           din_ready,
  input  logic [7:0]     din,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic [7:0]     dout,
  output logic           core_key_valid,
  output logic           core_key_last,
  output logic [7:0]     core_key_byte,
  input  logic           core_key_ready,
  output logic           core_init,
  input  logic           core_init_done,
  input  logic           core_ks_valid,
  input  logic [7:0]     core_ks_byte,
  output logic           core_ks_ready,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int TW = $clog2(KSA_TIMEOUT + 1);

  rc4_state_e     state_r;
  logic [KAW-1:0] idx_r;
  logic [KLW-1:0] key_len_r;
  logic [15:0]    rem_r;
  logic [TW-1:0]  ksa_cnt_r;

  logic           core_key_valid_r;
  logic           core_key_last_r;
  logic [7:0]     core_key_byte_r;
  logic           core_init_r;
  logic           dout_valid_r;
  logic [7:0]     dout_r;
  logic           busy_r;
  logic           done_r;
  logic           err_r;

  logic           key_hs_s;
  logic           take_s;
  logic           buf_we_s;
  logic [KAW-1:0] rd_addr_s;
  logic [7:0]     rd_data_s;

  assign key_hs_s = core_key_valid_r & core_key_ready;
  assign buf_we_s = key_we & (state_r == ST_IDLE);

  // Look one byte ahead on a key handshake so core_key_byte can be registered
  always_comb begin
    rd_addr_s = idx_r;
    if ((state_r == ST_LOAD_KEY) && key_hs_s) begin
      rd_addr_s = idx_r + {{(KAW-1){1'b0}}, 1'b1};
    end else begin
      rd_addr_s = idx_r;
    end
  end

  // A byte moves only when plaintext, keystream and output space are all present
  always_comb begin
    take_s = 1'b0;
    if (state_r == ST_STREAM) begin
      take_s = din_valid & core_ks_valid & (~dout_valid_r | dout_ready);
    end else begin
      take_s = 1'b0;
    end
  end

  rc4_key_buf #(
    .DEPTH (KEY_MAX)
  ) u_key_buf (
    .clk   (wb_clk_i),
    .we    (buf_we_s),
    .waddr (key_addr),
    .wdata (key_data),
    .raddr (rd_addr_s),
    .rdata (rd_data_s)
  );

  // Session FSM with all registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r          <= ST_IDLE;
      idx_r            <= '0;
      key_len_r        <= '0;
      rem_r            <= 16'd0;
      ksa_cnt_r        <= '0;
      core_key_valid_r <= 1'b0;
      core_key_last_r  <= 1'b0;
      core_key_byte_r  <= 8'h00;
      core_init_r      <= 1'b0;
      dout_valid_r     <= 1'b0;
      dout_r           <= 8'h00;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      err_r            <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      core_init_r <= 1'b0;

      // Output register: a take overwrites, otherwise an accept drains it
      if (take_s) begin
        dout_r       <= din ^ core_ks_byte;
        dout_valid_r <= 1'b1;
      end else if (dout_valid_r && dout_ready) begin
        dout_valid_r <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (key_len_in_range(32'(key_len), 32'(KEY_MAX))) begin
              key_len_r        <= key_len;
              rem_r            <= msg_len;
              err_r            <= 1'b0;
              busy_r           <= 1'b1;
              idx_r            <= '0;
              core_key_valid_r <= 1'b1;
              core_key_byte_r  <= rd_data_s;
              core_key_last_r  <= (key_len == KLW'(1));
              state_r          <= ST_LOAD_KEY;
            end else begin
              err_r <= 1'b1;
            end
          end
        end

        ST_LOAD_KEY: begin
          if (key_hs_s) begin
            if (KLW'(idx_r) == (key_len_r - KLW'(1))) begin
              core_key_valid_r <= 1'b0;
              core_key_last_r  <= 1'b0;
              core_init_r      <= 1'b1;
              ksa_cnt_r        <= '0;
              idx_r            <= '0;
              state_r          <= ST_KSA_WAIT;
            end else begin
              idx_r           <= rd_addr_s;
              core_key_byte_r <= rd_data_s;
              core_key_last_r <= ((KLW'(idx_r) + KLW'(2)) == key_len_r);
            end
          end
        end

        ST_KSA_WAIT: begin
          if (core_init_done) begin
            ksa_cnt_r <= '0;
            if (rem_r == 16'd0) begin
              state_r <= ST_FINISH;
            end else begin
              state_r <= ST_STREAM;
            end
          end else if (ksa_cnt_r == TW'(KSA_TIMEOUT - 1)) begin
            ksa_cnt_r <= '0;
            err_r     <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            ksa_cnt_r <= ksa_cnt_r + TW'(1);
          end
        end

        ST_STREAM: begin
          if (take_s) begin
            rem_r <= rem_r - 16'd1;
            if (rem_r == 16'd1) begin
              state_r <= ST_FINISH;
            end
          end
        end

        ST_FINISH: begin
          // Done only once the last ciphertext byte has left the register
          if (!dout_valid_r || dout_ready) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end

        default: begin
          state_r          <= ST_IDLE;
          busy_r           <= 1'b0;
          core_key_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready      = take_s;
  assign core_ks_ready  = take_s;
  assign dout_valid     = dout_valid_r;
  assign dout           = dout_r;
  assign core_key_valid = core_key_valid_r;
  assign core_key_last  = core_key_last_r;
  assign core_key_byte  = core_key_byte_r;
  assign core_init      = core_init_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign err            = err_r;

endmodule
